// File: rtl/lsu_mem_arbiter_if.sv
// rtl/lsu_mem_arbiter_if.sv - data-memory port bundle between the LSU arbiter and dmem
interface lsu_mem_arbiter_if #(
  parameter int DMEM_ADDR_W = 10
);
  logic                   dmem_req_o;
  logic                   dmem_we_o;
  logic [DMEM_ADDR_W-1:0] dmem_addr_o;
  logic [3:0]             dmem_be_o;
  logic [31:0]            dmem_wdata_o;
  logic                   dmem_gnt_i;
  logic                   dmem_rvalid_i;
  logic [31:0]            dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - serializes the two LSU slots onto one dmem port, slot 0 first
module lsu_mem_arbiter #(
  parameter int DMEM_ADDR_W = 10
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_0_i,
  input  logic        req_1_i,
  input  logic        we_0_i,
  input  logic        we_1_i,
  input  logic [31:0] addr_0_i,
  input  logic [31:0] addr_1_i,
  input  logic [31:0] wdata_0_i,
  input  logic [31:0] wdata_1_i,
  input  logic [1:0]  size_0_i,
  input  logic [1:0]  size_1_i,
  input  logic        uns_0_i,
  input  logic        uns_1_i,
  input  logic        backend_we_i,
  lsu_mem_arbiter_if.master dmem,
  output logic [31:0] rdata_0_o,
  output logic [31:0] rdata_1_o,
  output logic        mem_stall_o
);

  logic        fresh;
  logic [1:0]  pend_r;
  logic        wait_r;
  logic        wait_slot_r;
  logic [31:0] rdata_0_r;
  logic [31:0] rdata_1_r;

  logic [1:0]  eff;
  logic [1:0]  done;
  logic [1:0]  eff_next;
  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_size;
  logic        grant;
  logic        resp;
  logic [31:0] resp_data;
  logic [31:0] resp_addr;
  logic [1:0]  resp_size;
  logic        resp_uns;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'd1:    return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign eff = fresh ? {req_1_i, req_0_i} : pend_r;
  assign sel = ~eff[0];

  always_comb begin
    sel_we    = sel ? we_1_i    : we_0_i;
    sel_addr  = sel ? addr_1_i  : addr_0_i;
    sel_wdata = sel ? wdata_1_i : wdata_0_i;
    sel_size  = sel ? size_1_i  : size_0_i;
  end

  // Store lanes: data replicated so the byte enables alone pick the target bytes.
  always_comb begin
    dmem.dmem_be_o    = 4'b1111;
    dmem.dmem_wdata_o = sel_wdata;
    case (sel_size)
      2'd0: begin
        dmem.dmem_be_o    = 4'b0001 << sel_addr[1:0];
        dmem.dmem_wdata_o = {4{sel_wdata[7:0]}};
      end
      2'd1: begin
        dmem.dmem_be_o    = sel_addr[1] ? 4'b1100 : 4'b0011;
        dmem.dmem_wdata_o = {2{sel_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign dmem.dmem_req_o  = (|eff) && !wait_r;
  assign dmem.dmem_we_o   = sel_we;
  assign dmem.dmem_addr_o = sel_addr[DMEM_ADDR_W+1:2];

  assign grant = dmem.dmem_req_o && dmem.dmem_gnt_i;
  assign resp  = dmem.dmem_rvalid_i && wait_r;

  always_comb begin
    done = 2'b00;
    if (grant && sel_we) done[sel] = 1'b1;
    if (resp)            done[wait_slot_r] = 1'b1;
  end

  assign eff_next    = eff & ~done;
  assign mem_stall_o = |eff_next;

  // The LSU registers hold the bundle while stalled, so the waiting slot's fields are still valid.
  always_comb begin
    resp_addr = wait_slot_r ? addr_1_i : addr_0_i;
    resp_size = wait_slot_r ? size_1_i : size_0_i;
    resp_uns  = wait_slot_r ? uns_1_i  : uns_0_i;
    resp_data = load_ext(dmem.dmem_rdata_i, resp_addr[1:0], resp_size, resp_uns);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fresh       <= 1'b1;
      pend_r      <= 2'b00;
      wait_r      <= 1'b0;
      wait_slot_r <= 1'b0;
      rdata_0_r   <= 32'b0;
      rdata_1_r   <= 32'b0;
    end else begin
      fresh  <= backend_we_i;
      pend_r <= eff_next;
      if (resp) begin
        wait_r <= 1'b0;
        if (wait_slot_r) rdata_1_r <= resp_data;
        else             rdata_0_r <= resp_data;
      end else if (grant && !sel_we) begin
        wait_r      <= 1'b1;
        wait_slot_r <= sel;
      end
    end
  end

  assign rdata_0_o = (resp && !wait_slot_r) ? resp_data : rdata_0_r;
  assign rdata_1_o = (resp &&  wait_slot_r) ? resp_data : rdata_1_r;

  logic unused_bits;
  assign unused_bits = ^{addr_0_i[31:DMEM_ADDR_W+2], addr_1_i[31:DMEM_ADDR_W+2]};

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb/tb_lsu_mem_arbiter.sv - directed self-checking bench for lsu_mem_arbiter
module tb_lsu_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_0, req_1, we_0, we_1, uns_0, uns_1, backend_we;
  logic [31:0] addr_0, addr_1, wdata_0, wdata_1;
  logic [1:0]  size_0, size_1;
  logic [31:0] rdata_0, rdata_1;
  logic        stall;
  int          checks = 0;
  int          errors = 0;
  int          pulses;

  lsu_mem_arbiter_if #(.DMEM_ADDR_W(10)) dmem ();

  lsu_mem_arbiter #(.DMEM_ADDR_W(10)) dut (
    .clock_i(clk), .reset_i(rst),
    .req_0_i(req_0), .req_1_i(req_1), .we_0_i(we_0), .we_1_i(we_1),
    .addr_0_i(addr_0), .addr_1_i(addr_1), .wdata_0_i(wdata_0), .wdata_1_i(wdata_1),
    .size_0_i(size_0), .size_1_i(size_1), .uns_0_i(uns_0), .uns_1_i(uns_1),
    .backend_we_i(backend_we), .dmem(dmem.master),
    .rdata_0_o(rdata_0), .rdata_1_o(rdata_1), .mem_stall_o(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    req_0 = 0; req_1 = 0; dmem.dmem_rvalid_i = 0; dmem.dmem_gnt_i = 1; backend_we = 1;
    step();
  endtask

  initial begin
    rst = 1; req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0; uns_0 = 0; uns_1 = 0;
    addr_0 = 0; addr_1 = 0; wdata_0 = 0; wdata_1 = 0; size_0 = 0; size_1 = 0;
    backend_we = 0;
    dmem.dmem_gnt_i = 0; dmem.dmem_rvalid_i = 0; dmem.dmem_rdata_i = 0;
    step(); step();
    rst = 0;
    #1;
    check("rst_req", dmem.dmem_req_o, 0);
    check("rst_stall", stall, 0);
    check("rst_rdata0", rdata_0, 0);
    check("rst_rdata1", rdata_1, 0);

    // Byte store at 0x13 on slot 0, immediate grant
    req_0 = 1; we_0 = 1; addr_0 = 32'h13; size_0 = 0; wdata_0 = 32'hAB;
    dmem.dmem_gnt_i = 1; backend_we = 1;
    #1;
    check("st_req", dmem.dmem_req_o, 1);
    check("st_we", dmem.dmem_we_o, 1);
    check("st_be", dmem.dmem_be_o, 4'b1000);
    check("st_wdata", dmem.dmem_wdata_o, 32'hABABABAB);
    check("st_addr", dmem.dmem_addr_o, 10'h4);
    check("st_stall", stall, 0);
    step();
    idle();

    // Two word loads, slot 0 then slot 1
    req_0 = 1; req_1 = 1; we_0 = 0; we_1 = 0; addr_0 = 32'h20; addr_1 = 32'h24;
    size_0 = 2; size_1 = 2; backend_we = 0;
    #1;
    check("ll_c0_req", dmem.dmem_req_o, 1);
    check("ll_c0_addr", dmem.dmem_addr_o, 10'h8);
    check("ll_c0_stall", stall, 1);
    step();
    dmem.dmem_rvalid_i = 1; dmem.dmem_rdata_i = 32'h11223344;
    #1;
    check("ll_c1_req", dmem.dmem_req_o, 0);
    check("ll_c1_rdata0", rdata_0, 32'h11223344);
    check("ll_c1_stall", stall, 1);
    step();
    dmem.dmem_rvalid_i = 0;
    #1;
    check("ll_c2_req", dmem.dmem_req_o, 1);
    check("ll_c2_addr", dmem.dmem_addr_o, 10'h9);
    check("ll_c2_stall", stall, 1);
    check("ll_c2_rdata0", rdata_0, 32'h11223344);
    step();
    dmem.dmem_rvalid_i = 1; dmem.dmem_rdata_i = 32'h55667788; backend_we = 1;
    #1;
    check("ll_c3_req", dmem.dmem_req_o, 0);
    check("ll_c3_stall", stall, 0);
    check("ll_c3_rdata1", rdata_1, 32'h55667788);
    step();
    idle();
    check("ll_hold_rdata1", rdata_1, 32'h55667788);

    // Signed then unsigned byte load from lane 2
    req_0 = 1; we_0 = 0; addr_0 = 32'h2; size_0 = 0; uns_0 = 0; backend_we = 0;
    step();
    dmem.dmem_rvalid_i = 1; dmem.dmem_rdata_i = 32'h00800000; backend_we = 1;
    #1;
    check("lb_signed", rdata_0, 32'hFFFFFF80);
    check("lb_s_stall", stall, 0);
    step();
    dmem.dmem_rvalid_i = 0; uns_0 = 1; backend_we = 0;
    step();
    dmem.dmem_rvalid_i = 1; backend_we = 1;
    #1;
    check("lb_unsigned", rdata_0, 32'h00000080);
    step();
    idle();

    // Slot 1 word store held by an external stall for 5 cycles
    req_1 = 1; we_1 = 1; addr_1 = 32'h8; size_1 = 2; wdata_1 = 32'hDEADBEEF; backend_we = 0;
    #1;
    check("s1_addr", dmem.dmem_addr_o, 10'h2);
    check("s1_be", dmem.dmem_be_o, 4'b1111);
    check("s1_wdata", dmem.dmem_wdata_o, 32'hDEADBEEF);
    check("s1_stall", stall, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (dmem.dmem_req_o) pulses++;
      step();
    end
    check("s1_pulses", pulses, 1);
    idle();

    // Half store at 0x6 with grant withheld for 3 cycles
    req_0 = 1; we_0 = 1; addr_0 = 32'h6; size_0 = 1; wdata_0 = 32'h00001234;
    dmem.dmem_gnt_i = 0; backend_we = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("gw_req", dmem.dmem_req_o, 1);
      check("gw_addr", dmem.dmem_addr_o, 10'h1);
      check("gw_be", dmem.dmem_be_o, 4'b1100);
      check("gw_wdata", dmem.dmem_wdata_o, 32'h12341234);
      check("gw_stall", stall, 1);
      step();
    end
    dmem.dmem_gnt_i = 1; backend_we = 1;
    #1;
    check("gw_gnt_req", dmem.dmem_req_o, 1);
    check("gw_gnt_stall", stall, 0);
    step();
    idle();

    // Reset while a load is outstanding, then a late rvalid
    req_0 = 1; we_0 = 0; addr_0 = 32'h0; size_0 = 2; backend_we = 0;
    step();
    rst = 1;
    step();
    rst = 0; req_0 = 0; dmem.dmem_rvalid_i = 1; dmem.dmem_rdata_i = 32'hCAFEF00D; backend_we = 1;
    #1;
    check("rs_rdata0", rdata_0, 0);
    check("rs_rdata1", rdata_1, 0);
    check("rs_stall", stall, 0);
    check("rs_req", dmem.dmem_req_o, 0);
    step();
    dmem.dmem_rvalid_i = 0; req_1 = 1; we_1 = 0; addr_1 = 32'h4; size_1 = 2; backend_we = 0;
    #1;
    check("rs_next_req", dmem.dmem_req_o, 1);
    check("rs_next_addr", dmem.dmem_addr_o, 10'h1);
    check("rs_next_stall", stall, 1);
    step();
    dmem.dmem_rvalid_i = 1; dmem.dmem_rdata_i = 32'h0BADBEEF; backend_we = 1;
    #1;
    check("rs_next_rdata1", rdata_1, 32'h0BADBEEF);
    check("rs_next_done", stall, 0);
    step();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
